chunk_add_sequencer: RTL



---
 rtl/chunk_add_sequencer_pkg.sv | 24 ++
 rtl/chunk_add_sequencer_slice.sv | 25 ++
 rtl/chunk_add_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/chunk_add_sequencer_pkg.sv
// Shared definitions for the chunked multi-cycle adder: state encoding,
// slice width and the sizing helpers derived from the operand width.
package chunk_add_sequencer_pkg;

    localparam int SLICE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int chunks_of(input int width);
        return width / SLICE_W;
    endfunction

    // Index counter needs at least one bit even for a single-chunk adder.
    function automatic int idxw_of(input int width);
        int chunks;
        chunks = chunks_of(width);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/chunk_add_sequencer_slice.sv
// 3-bit combinational ripple slice; exposes every internal carry so the
// sequencer can recover the carry into the operand MSB for overflow.
module add_slice3 (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       cin,
    output logic [2:0] s,
    output logic [2:0] c
);

    always_comb begin
        logic cy;
        // NOTE: blocking assignments here so each bit sees the carry computed
        // by the previous iteration within the same evaluation.
        cy = cin;
        s  = '0;
        c  = '0;
        for (int i = 0; i < 3; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
            c[i] = cy;
        end
    end

endmodule

// File: rtl/chunk_add_sequencer.sv
// Low-area wide adder: one 3-bit slice iterated LSB chunk first, with the
// inter-chunk carry held in a register and valid/ready on both sides.
module chunk_add_sequencer
    import chunk_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int CHUNKS = chunks_of(WIDTH);
    localparam int IDXW   = idxw_of(WIDTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
            $error("chunk_add_sequencer: WIDTH must be a positive multiple of 3");
        end
    endgenerate

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  sum_r;
    logic              carry_r;
    logic              msb_cin_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic [SLICE_W-1:0] sl_c;

    assign sl_a = a_r[SLICE_W*int'(idx) +: SLICE_W];
    assign sl_b = b_r[SLICE_W*int'(idx) +: SLICE_W];

    add_slice3 u_slice (
        .a   (sl_a),
        .b   (sl_b),
        .cin (carry_r),
        .s   (sl_s),
        .c   (sl_c)
    );

    // Handshake flags are registered alongside the state so they always
    // match it; each transition updates all of them together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            msb_cin_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b;
                        carry_r    <= c_in;
                        idx        <= '0;
                        state      <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_r[SLICE_W*int'(idx) +: SLICE_W] <= sl_s;
                    carry_r <= sl_c[SLICE_W-1];
                    if (idx == LAST_IDX) begin
                        msb_cin_r   <= sl_c[SLICE_W-2];
                        idx         <= '0;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid_r && out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    idx         <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign c_out     = carry_r;
    assign ovf       = msb_cin_r ^ carry_r;

endmodule
